// File: rtl/load_store_unit.sv
// Load/store unit: turns execute-stage load/store requests into word accesses on a
// single-write-enable data cache, with lane extraction on loads and read-modify-write for SB/SH.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_store_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            resp_err_o,
    output logic [XLEN-1:0] dcache_addr_o,
    output logic            dcache_read_en_o,
    output logic            dcache_write_en_o,
    output logic [XLEN-1:0] dcache_write_data_o,
    input  logic [XLEN-1:0] dcache_read_data_i,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RMW_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      lane_q, lane_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            rd_en_d, wr_en_d, resp_valid_d, resp_err_d;
    logic [XLEN-1:0] addr_d, wr_data_d, resp_rdata_d;

    logic            accept, req_illegal, req_misaligned, req_err;
    logic [4:0]      byte_shift, half_shift;
    logic [XLEN-1:0] lane_data, load_ext, byte_mask, half_mask, merged;

    // Valid/ready: a request transfers on any rising edge where req_valid_i && req_ready_o;
    // only one request is ever in flight, and ready drops for the whole operation.
    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;
    assign dbg_state_o = state_q;

    always_comb begin
        req_illegal = 1'b0;
        if (req_store_i) begin
            req_illegal = !(req_funct3_i == 3'd0 || req_funct3_i == 3'd1 || req_funct3_i == 3'd2);
        end else begin
            req_illegal = (req_funct3_i == 3'd3 || req_funct3_i == 3'd6 || req_funct3_i == 3'd7);
        end
        case (req_funct3_i[1:0])
            2'b01:   req_misaligned = req_addr_i[0];
            2'b10:   req_misaligned = (req_addr_i[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
        req_err = req_illegal || req_misaligned;
    end

    // Lane extraction for loads and lane merge for sub-word stores, both from the returned word.
    always_comb begin
        byte_shift = {lane_q, 3'b000};
        half_shift = {lane_q[1], 4'b0000};
        lane_data  = dcache_read_data_i >> byte_shift;
        case (funct3_q)
            3'd0:    load_ext = {{(XLEN-8){lane_data[7]}}, lane_data[7:0]};
            3'd1:    load_ext = {{(XLEN-16){lane_data[15]}}, lane_data[15:0]};
            3'd4:    load_ext = {{(XLEN-8){1'b0}}, lane_data[7:0]};
            3'd5:    load_ext = {{(XLEN-16){1'b0}}, lane_data[15:0]};
            default: load_ext = dcache_read_data_i;
        endcase
        byte_mask = {{(XLEN-8){1'b0}}, 8'hFF} << byte_shift;
        half_mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << half_shift;
        if (funct3_q == 3'd0) begin
            merged = (dcache_read_data_i & ~byte_mask)
                   | ({{(XLEN-8){1'b0}}, wdata_q[7:0]} << byte_shift);
        end else begin
            merged = (dcache_read_data_i & ~half_mask)
                   | ({{(XLEN-16){1'b0}}, wdata_q[15:0]} << half_shift);
        end
    end

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        addr_d       = dcache_addr_o;
        wr_data_d    = dcache_write_data_o;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d = req_funct3_i;
                    lane_d   = req_addr_i[1:0];
                    wdata_d  = req_wdata_i;
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        state_d      = RESP;
                    end else if (!req_store_i) begin
                        rd_en_d = 1'b1;
                        addr_d  = {req_addr_i[XLEN-1:2], 2'b00};
                        state_d = RD_WAIT;
                    end else if (req_funct3_i == 3'd2) begin
                        wr_en_d      = 1'b1;
                        addr_d       = {req_addr_i[XLEN-1:2], 2'b00};
                        wr_data_d    = req_wdata_i;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        rd_en_d = 1'b1;
                        addr_d  = {req_addr_i[XLEN-1:2], 2'b00};
                        state_d = RMW_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                resp_rdata_d = load_ext;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RMW_WAIT: begin
                wr_en_d      = 1'b1;
                wr_data_d    = merged;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q             <= IDLE;
            funct3_q            <= '0;
            lane_q              <= '0;
            wdata_q             <= '0;
            dcache_read_en_o    <= 1'b0;
            dcache_write_en_o   <= 1'b0;
            dcache_addr_o       <= '0;
            dcache_write_data_o <= '0;
            resp_valid_o        <= 1'b0;
            resp_err_o          <= 1'b0;
            resp_rdata_o        <= '0;
        end else begin
            state_q             <= state_d;
            funct3_q            <= funct3_d;
            lane_q              <= lane_d;
            wdata_q             <= wdata_d;
            dcache_read_en_o    <= rd_en_d;
            dcache_write_en_o   <= wr_en_d;
            dcache_addr_o       <= addr_d;
            dcache_write_data_o <= wr_data_d;
            resp_valid_o        <= resp_valid_d;
            resp_err_o          <= resp_err_d;
            resp_rdata_o        <= resp_rdata_d;
        end
    end

endmodule
